branch_operand_scoreboard: RTL and testbench
============================================

Name: branch_operand_scoreboard

Overview:
- Tracks in-flight register writes issued into ID/EX and stalls any ID-stage branch or jr whose source operand cannot be forwarded yet.
- This is the producer-side counterpart to the ID-stage branch forwarding selector. That selector only picks forward paths; this block decides when those paths do not yet hold valid data, for example a load still in EX or MEM.
- Sits beside the hazard/stall logic in ID and drives the PC/IF_ID hold and the ID/EX bubble insertion.

Parameters:
- LOAD_LAT, 2: stall cycles a dependent branch needs after a load issues.
- ALU_LAT, 0: stall cycles after an ALU-result instruction issues. 0 means the value is fully forwardable and no entry is made.
- CNT_W, 2: width of each per-register countdown. Must hold max(LOAD_LAT, ALU_LAT).
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous active-low reset.
- IF_ID_RegisterRs, input, 5: rs field of the instruction in ID.
- IF_ID_RegisterRt, input, 5: rt field of the instruction in ID.
- Branch, input, 1: the ID instruction is a conditional branch and reads rs and rt.
- Jr, input, 1: the ID instruction is jr and reads rs only.
- IssueValid, input, 1: an instruction leaves ID into ID/EX at this edge. The pipeline forces it low whenever Stall=1.
- IssueRegDst, input, 5: destination register of the issuing instruction.
- IssueIsLoad, input, 1: the issuing instruction is a load.
- IssueWrites, input, 1: the issuing instruction writes a register.
- Flush, input, 1: synchronous pipeline flush (mispredict or redirect).
- Stall, output, 1: combinational. Hold PC and IF_ID, bubble ID/EX.
- BusyMask, output, 32: registered. Bit r=1 when cnt[r]!=0.
- StallCycles, output, PERF_W: registered saturating count of cycles with Stall=1.

Behaviour:
- State: cnt[1..31], each CNT_W bits. Register 0 has no storage; cnt[0] reads 0 permanently.
- Reset (Rst_n=0, asynchronous): all cnt=0, BusyMask=0, StallCycles=0. Stall is then 0 because it is derived from cnt.
- Stall = (Branch|Jr) & (cnt[IF_ID_RegisterRs]!=0) | Branch & (cnt[IF_ID_RegisterRt]!=0).
  - Jr ignores rt.
  - Stall is 0 when neither Branch nor Jr is set.
- Per-register update at each rising edge, in priority order:
  1. Flush=1: all cnt cleared to 0, including any same-edge issue. Flushed instructions are squashed.
  2. IssueValid & IssueWrites & IssueRegDst!=0 & r==IssueRegDst: cnt[r] loads (IssueIsLoad ? LOAD_LAT : ALU_LAT). This overwrites any older pending value, because the youngest writer wins.
  3. Otherwise, if cnt[r]!=0: cnt[r] decrements by 1. It never wraps below 0.
- Issue and decrement on the same register at the same edge: the issue load wins and there is no decrement that cycle.
- Latency: a load issued at edge E makes Stall=1 for a dependent branch during the 2 cycles after E (LOAD_LAT=2). At edge E+2, cnt reaches 0 and Stall drops. The branch then resolves using MEM/WB forwarding.
- An IssueValid arriving while Stall=1 is a protocol violation. The block still applies the update. The bench must flag it with an assertion.
- BusyMask is the registered view of cnt!=0 for r=1..31. Bit 0 is always 0.
- StallCycles increments at each edge where Stall=1 and Flush=0, and saturates at all-ones. Only reset clears it.
- A reset deasserted mid-stall leaves the block idle. Any pending-write history is lost by design.

Test Plan:
- Load-use on branch: issue lw $5 (IssueIsLoad=1, RegDst=5), then hold Branch=1 with Rs=5 → Stall=1 for exactly 2 cycles, 0 on the third. BusyMask bit5 is high for 2 cycles. StallCycles=2.
- ALU producer: issue add $7, then Branch with Rt=7 → Stall never asserts (ALU_LAT=0). BusyMask stays 0.
- Jr vs rt: lw $9 pending, Jr=1, Rs=3, Rt=9 → Stall=0. The same fields with Branch=1 → Stall=1.
- $0 and non-writers: lw to RegDst=0, or IssueWrites=0 with RegDst=4 → BusyMask stays 0. A branch on $0 or $4 never stalls.
- Overwrite and flush:
  - lw $6, next cycle add $6 → cnt[6]=0 after the second edge and Stall clears one cycle early.
  - lw $6 followed by Flush the next cycle → BusyMask=0 immediately after the flush edge.
- Async reset: assert Rst_n=0 mid-cycle while cnt[5]=2 and StallCycles=5 → BusyMask=0, StallCycles=0 and Stall=0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_operand_scoreboard.sv
// Per-register countdown of in-flight writes that are not yet forwardable.
// Stalls an ID-stage branch/jr until its rs/rt producer can be forwarded.
//
// Ports:
//   Clk, Rst_n            clock, async active-low reset
//   IF_ID_RegisterRs/Rt   source fields of the instruction in ID
//   Branch, Jr            ID instruction kind (branch reads rs+rt, jr reads rs)
//   IssueValid            instruction enters ID/EX at this edge
//   IssueRegDst           its destination register
//   IssueIsLoad           it is a load
//   IssueWrites           it writes a register
//   Flush                 squash everything in flight
//   Stall                 comb: hold PC/IF_ID, bubble ID/EX
//   BusyMask              registered cnt!=0 per register
//   StallCycles           registered saturating stall-cycle count
module branch_operand_scoreboard #(
  parameter int LOAD_LAT = 2,
  parameter int ALU_LAT  = 0,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic              Branch,
  input  logic              Jr,
  input  logic              IssueValid,
  input  logic [4:0]        IssueRegDst,
  input  logic              IssueIsLoad,
  input  logic              IssueWrites,
  input  logic              Flush,
  output logic              Stall,
  output logic [31:0]       BusyMask,
  output logic [PERF_W-1:0] StallCycles
);

  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT);

  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [31:0]       busy_d;
  logic [PERF_W-1:0] sc_q;
  logic              issue_hit;
  logic              rs_busy;
  logic              rt_busy;

  // Entry 0 is forced to zero every cycle, so $0 never reads busy.
  assign rs_busy = cnt_q[IF_ID_RegisterRs] != '0;
  assign rt_busy = cnt_q[IF_ID_RegisterRt] != '0;

  assign Stall = ((Branch | Jr) & rs_busy)
               | (Branch & rt_busy);

  assign issue_hit = IssueValid & IssueWrites
                   & (IssueRegDst != 5'd0);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r]  = cnt_q[r];
      busy_d[r] = 1'b0;
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (Flush) begin
        cnt_d[r] = '0;
      end else if (issue_hit && IssueRegDst == 5'(r)) begin
        // Youngest writer overrides any older pending value.
        cnt_d[r] = IssueIsLoad ? LOAD_V : ALU_V;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      busy_d[r] = (r != 0) && (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      BusyMask <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      BusyMask <= busy_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sc_q <= '0;
    end else if (Stall && !Flush && sc_q != '1) begin
      sc_q <= sc_q + PERF_W'(1);
    end
  end

  assign StallCycles = sc_q;

endmodule

// File: tb/tb_branch_operand_scoreboard.sv
// Directed bench for branch_operand_scoreboard with a ready-time model.
// Model tracks the cycle at which each register's value becomes forwardable.
module tb_branch_operand_scoreboard;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  IF_ID_RegisterRs = '0;
  logic [4:0]  IF_ID_RegisterRt = '0;
  logic        Branch = 1'b0;
  logic        Jr = 1'b0;
  logic        IssueValid = 1'b0;
  logic [4:0]  IssueRegDst = '0;
  logic        IssueIsLoad = 1'b0;
  logic        IssueWrites = 1'b0;
  logic        Flush = 1'b0;
  logic        Stall;
  logic [31:0] BusyMask;
  logic [15:0] StallCycles;

  int checks = 0;
  int failures = 0;

  branch_operand_scoreboard dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .Branch(Branch),
    .Jr(Jr),
    .IssueValid(IssueValid),
    .IssueRegDst(IssueRegDst),
    .IssueIsLoad(IssueIsLoad),
    .IssueWrites(IssueWrites),
    .Flush(Flush),
    .Stall(Stall),
    .BusyMask(BusyMask),
    .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  // Model: a register is busy while the current edge count is below
  // the edge count at which its producer becomes forwardable.
  int          cyc = 0;
  int          ready_at [32];
  logic [15:0] m_sc = '0;

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 5'd0) && (ready_at[r] > cyc);
  endfunction

  function automatic logic m_stall();
    logic s;
    s = 1'b0;
    if ((Branch || Jr) && m_busy(IF_ID_RegisterRs)) s = 1'b1;
    if (Branch && m_busy(IF_ID_RegisterRt)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    for (int r = 0; r < 32; r++) m[r] = m_busy(5'(r));
    return m;
  endfunction

  initial for (int r = 0; r < 32; r++) ready_at[r] = 0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cyc = 0;
      m_sc = '0;
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
    end else begin
      logic s;
      s = m_stall();
      if (Flush) begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end else begin
        if (s && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (IssueValid && IssueWrites && IssueRegDst != 5'd0)
          ready_at[IssueRegDst] = cyc + 1 + (IssueIsLoad ? 2 : 0);
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("model_stall", {31'd0, Stall}, {31'd0, m_stall()});
      chk("model_busy", BusyMask, m_mask());
      chk("model_sc", {16'd0, StallCycles}, {16'd0, m_sc});
    end
  end

  always @(posedge Clk) begin
    if (Rst_n)
      assert (!(IssueValid && Stall))
        else $error("protocol: IssueValid while Stall");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Branch = 0; Jr = 0; Flush = 0;
    IssueValid = 0; IssueWrites = 0; IssueIsLoad = 0;
    IssueRegDst = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld,
                       input logic wr);
    IssueValid = 1; IssueRegDst = rd; IssueIsLoad = ld; IssueWrites = wr;
  endtask

  task automatic no_issue();
    IssueValid = 0; IssueWrites = 0; IssueIsLoad = 0; IssueRegDst = 0;
  endtask

  initial begin
    idle();
    #12;
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    chk("reset_busy", BusyMask, 32'd0);
    chk("reset_sc", {16'd0, StallCycles}, 32'd0);
    Rst_n = 1;
    tick();

    // load-use on branch rs
    issue(5, 1, 1); tick();
    no_issue(); Branch = 1; IF_ID_RegisterRs = 5; #1;
    chk("lu_stall0", {31'd0, Stall}, 32'd1);
    chk("lu_busy0", BusyMask, 32'h20);
    tick();
    chk("lu_stall1", {31'd0, Stall}, 32'd1);
    tick();
    chk("lu_stall2", {31'd0, Stall}, 32'd0);
    chk("lu_busy2", BusyMask, 32'd0);
    chk("lu_sc", {16'd0, StallCycles}, 32'd2);
    idle(); tick();

    // ALU producer never stalls
    issue(7, 0, 1); tick();
    no_issue(); Branch = 1; IF_ID_RegisterRt = 7; #1;
    chk("alu_stall", {31'd0, Stall}, 32'd0);
    chk("alu_busy", BusyMask, 32'd0);
    tick(); idle();

    // jr ignores rt, branch does not
    issue(9, 1, 1); tick();
    no_issue(); Jr = 1; IF_ID_RegisterRs = 3; IF_ID_RegisterRt = 9; #1;
    chk("jr_rt", {31'd0, Stall}, 32'd0);
    tick();
    Jr = 0; Branch = 1; #1;
    chk("br_rt", {31'd0, Stall}, 32'd1);
    tick(); idle();
    chk("br_rt_sc", {16'd0, StallCycles}, 32'd3);

    // $0 and non-writers
    issue(0, 1, 1); tick();
    chk("r0_busy", BusyMask, 32'd0);
    issue(4, 1, 0); tick();
    chk("nw_busy", BusyMask, 32'd0);
    no_issue(); Branch = 1; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 4; #1;
    chk("r0_nw_stall", {31'd0, Stall}, 32'd0);
    tick(); idle();

    // overwrite by younger ALU writer
    issue(6, 1, 1); tick();
    chk("ow_busy1", BusyMask, 32'h40);
    issue(6, 0, 1); tick();
    chk("ow_busy2", BusyMask, 32'd0);
    no_issue(); Branch = 1; IF_ID_RegisterRs = 6; #1;
    chk("ow_stall", {31'd0, Stall}, 32'd0);
    tick(); idle();

    // flush clears pending and same-edge issue
    issue(6, 1, 1); tick();
    chk("fl_busy_pre", BusyMask, 32'h40);
    no_issue(); Flush = 1; tick();
    chk("fl_busy", BusyMask, 32'd0);
    issue(8, 1, 1); tick();
    chk("fl_issue", BusyMask, 32'd0);
    idle();
    issue(10, 1, 1); tick();
    no_issue(); Branch = 1; IF_ID_RegisterRs = 10; Flush = 1; #1;
    chk("fl_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("fl_sc", {16'd0, StallCycles}, 32'd3);
    chk("fl_stall_after", {31'd0, Stall}, 32'd0);
    idle(); tick();

    // async reset mid-stall
    issue(5, 1, 1); tick();
    no_issue(); Branch = 1; IF_ID_RegisterRs = 5;
    tick(); tick();
    Branch = 0; issue(5, 1, 1); tick();
    no_issue(); Branch = 1; IF_ID_RegisterRs = 5; #1;
    chk("ar_pre_stall", {31'd0, Stall}, 32'd1);
    chk("ar_pre_busy", BusyMask, 32'h20);
    chk("ar_pre_sc", {16'd0, StallCycles}, 32'd5);
    #1;
    Rst_n = 0;
    #1;
    chk("ar_stall", {31'd0, Stall}, 32'd0);
    chk("ar_busy", BusyMask, 32'd0);
    chk("ar_sc", {16'd0, StallCycles}, 32'd0);
    @(negedge Clk); #1;
    Rst_n = 1;
    tick(); tick();
    chk("ar_idle", {31'd0, Stall}, 32'd0);
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
